// File: rtl/test_monitor.sv
// test_monitor: watches a DUT's retired-instruction count and WWD output
// port against a preloaded table of (instruction count, expected value)
// entries, tallies passes/fails/skipped entries and ends the run on halt,
// first failure (optional) or a cycle budget.
module test_monitor #(
  parameter int WORD_SIZE    = 16,
  parameter int NUM_TEST     = 56,
  parameter int IDX_W        = 6,
  parameter int MAX_CYCLES   = 10000,
  parameter int CYC_W        = 16,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_en,
  input  logic [IDX_W-1:0]     load_idx,
  input  logic [WORD_SIZE-1:0] load_inst,
  input  logic [WORD_SIZE-1:0] load_ans,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] num_inst,
  input  logic [WORD_SIZE-1:0] output_port,
  input  logic                 is_halted,
  input  logic [WORD_SIZE-1:0] num_branch,
  input  logic [WORD_SIZE-1:0] num_branch_miss,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           done_cause,
  output logic [IDX_W:0]       pass_count,
  output logic [IDX_W:0]       fail_count,
  output logic [IDX_W:0]       miss_count,
  output logic [IDX_W:0]       checked_count,
  output logic [IDX_W-1:0]     first_fail_idx,
  output logic                 fail_seen,
  output logic                 all_pass,
  output logic [CYC_W-1:0]     cycle_count,
  output logic [WORD_SIZE-1:0] branch_hit
);

  localparam logic [IDX_W:0] LP_NT   = (IDX_W+1)'(NUM_TEST);
  localparam logic [CYC_W:0] LP_MAXC = (CYC_W+1)'(MAX_CYCLES);
  localparam int             LP_DEPTH = 2**IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0] C_HALT = 2'd0, C_FAIL = 2'd1, C_TIMEOUT = 2'd2, C_NONE = 2'd3;

  // Depth rounded up to a power of two so every index value is in range;
  // slots at or above NUM_TEST are never written and never read.
  logic [WORD_SIZE-1:0] r_inst [LP_DEPTH];
  logic [WORD_SIZE-1:0] r_ans  [LP_DEPTH];

  state_t               r_state;
  logic [IDX_W:0]       r_ptr;
  logic [IDX_W:0]       r_pass, r_fail, r_miss, r_chk;
  logic [IDX_W-1:0]     r_ffi;
  logic                 r_fseen;
  logic [1:0]           r_cause;
  logic [CYC_W-1:0]     r_cyc;
  logic [WORD_SIZE-1:0] r_bh;

  logic                 w_load_ok;
  logic                 w_valid;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_eq, w_gt, w_match, w_mis;
  logic                 w_timeout;
  logic                 w_end;
  logic [1:0]           w_cause;

  assign w_load_ok = load_en && (r_state == S_IDLE) && ({1'b0, load_idx} < LP_NT);
  assign w_valid   = r_ptr < LP_NT;
  assign w_idx     = r_ptr[IDX_W-1:0];
  assign w_eq      = w_valid && (num_inst == r_inst[w_idx]);
  assign w_gt      = w_valid && (num_inst >  r_inst[w_idx]);
  assign w_match   = w_eq && (output_port == r_ans[w_idx]);
  assign w_mis     = w_eq && (output_port != r_ans[w_idx]);
  assign w_timeout = ({1'b0, r_cyc} + 1'b1) == LP_MAXC;

  // End-of-run decision with fail > halt > timeout priority
  always_comb begin
    w_end   = 1'b0;
    w_cause = C_NONE;
    if (w_mis && (STOP_ON_FAIL != 0)) begin
      w_end   = 1'b1;
      w_cause = C_FAIL;
    end else if (is_halted) begin
      w_end   = 1'b1;
      w_cause = C_HALT;
    end else if (w_timeout) begin
      w_end   = 1'b1;
      w_cause = C_TIMEOUT;
    end
  end

  // Expected-result table; deliberately not reset so it survives a reset
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_inst[load_idx] <= load_inst;
      r_ans[load_idx]  <= load_ans;
    end
  end

  // Run-control FSM and tallies
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_pass  <= '0;
      r_fail  <= '0;
      r_miss  <= '0;
      r_chk   <= '0;
      r_ffi   <= '0;
      r_fseen <= 1'b0;
      r_cause <= C_NONE;
      r_cyc   <= '0;
      r_bh    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_ptr   <= '0;
            r_pass  <= '0;
            r_fail  <= '0;
            r_miss  <= '0;
            r_chk   <= '0;
            r_ffi   <= '0;
            r_fseen <= 1'b0;
            r_cause <= C_NONE;
            r_cyc   <= '0;
          end
        end
        S_RUN: begin
          if (r_cyc != '1) r_cyc <= r_cyc + 1'b1;
          if (w_eq || w_gt) begin
            r_ptr <= r_ptr + 1'b1;
            r_chk <= r_chk + 1'b1;
          end
          if (w_match) r_pass <= r_pass + 1'b1;
          if (w_gt)    r_miss <= r_miss + 1'b1;
          if (w_mis) begin
            r_fail <= r_fail + 1'b1;
            if (!r_fseen) begin
              r_fseen <= 1'b1;
              r_ffi   <= w_idx;
            end
          end
          if (w_end) begin
            r_state <= S_DONE;
            r_cause <= w_cause;
            r_bh    <= num_branch - num_branch_miss;
          end
        end
        S_DONE: begin
          if (start) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = (r_state == S_RUN);
  assign done           = (r_state == S_DONE);
  assign done_cause     = r_cause;
  assign pass_count     = r_pass;
  assign fail_count     = r_fail;
  assign miss_count     = r_miss;
  assign checked_count  = r_chk;
  assign first_fail_idx = r_ffi;
  assign fail_seen      = r_fseen;
  assign all_pass       = (r_state == S_DONE) && (r_pass == LP_NT);
  assign cycle_count    = r_cyc;
  assign branch_hit     = r_bh;

endmodule

// File: tb/tb_test_monitor.sv
// Bench for test_monitor: two instances share one stimulus bus, a default
// one (56 entries) and a small one (3 entries, 10-cycle budget).
module tb_test_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_en = 1'b0;
  logic [5:0]  load_idx = '0;
  logic [15:0] load_inst = '0, load_ans = '0;
  logic        start = 1'b0;
  logic [15:0] num_inst = '0, output_port = '0;
  logic        is_halted = 1'b0;
  logic [15:0] num_branch = '0, num_branch_miss = '0;

  logic        a_busy, a_done, a_fseen, a_allp;
  logic [1:0]  a_cause;
  logic [6:0]  a_pass, a_fail, a_miss, a_chk;
  logic [5:0]  a_ffi;
  logic [15:0] a_cyc, a_bh;

  logic        b_busy, b_done, b_fseen, b_allp;
  logic [1:0]  b_cause;
  logic [6:0]  b_pass, b_fail, b_miss, b_chk;
  logic [5:0]  b_ffi;
  logic [15:0] b_cyc, b_bh;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        done;
    logic        busy;
    logic [1:0]  cause;
    logic [6:0]  pass;
    logic [6:0]  fail;
    logic [6:0]  miss;
    logic [6:0]  chk;
    logic [5:0]  ffi;
    logic        fseen;
    logic        allp;
    logic [15:0] cyc;
    logic [15:0] bh;
  } res_t;

  res_t qa[$];
  res_t qb[$];
  res_t e, o;

  always #5 clk = ~clk;

  test_monitor u_a (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_idx(load_idx),
    .load_inst(load_inst), .load_ans(load_ans), .start(start),
    .num_inst(num_inst), .output_port(output_port), .is_halted(is_halted),
    .num_branch(num_branch), .num_branch_miss(num_branch_miss),
    .busy(a_busy), .done(a_done), .done_cause(a_cause),
    .pass_count(a_pass), .fail_count(a_fail), .miss_count(a_miss),
    .checked_count(a_chk), .first_fail_idx(a_ffi), .fail_seen(a_fseen),
    .all_pass(a_allp), .cycle_count(a_cyc), .branch_hit(a_bh)
  );

  test_monitor #(.NUM_TEST(3), .MAX_CYCLES(10)) u_b (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_idx(load_idx),
    .load_inst(load_inst), .load_ans(load_ans), .start(start),
    .num_inst(num_inst), .output_port(output_port), .is_halted(is_halted),
    .num_branch(num_branch), .num_branch_miss(num_branch_miss),
    .busy(b_busy), .done(b_done), .done_cause(b_cause),
    .pass_count(b_pass), .fail_count(b_fail), .miss_count(b_miss),
    .checked_count(b_chk), .first_fail_idx(b_ffi), .fail_seen(b_fseen),
    .all_pass(b_allp), .cycle_count(b_cyc), .branch_hit(b_bh)
  );

  function automatic res_t mk(logic d, logic b, logic [1:0] c, int p, int f,
                              int m, int k, int fi, logic fs, logic ap,
                              int cy, logic [15:0] bh);
    res_t r;
    r.done = d;  r.busy = b;  r.cause = c;
    r.pass = 7'(p); r.fail = 7'(f); r.miss = 7'(m); r.chk = 7'(k);
    r.ffi = 6'(fi); r.fseen = fs; r.allp = ap; r.cyc = 16'(cy); r.bh = bh;
    return r;
  endfunction

  function automatic res_t obs_a();
    return {a_done, a_busy, a_cause, a_pass, a_fail, a_miss, a_chk, a_ffi,
            a_fseen, a_allp, a_cyc, a_bh};
  endfunction

  function automatic res_t obs_b();
    return {b_done, b_busy, b_cause, b_pass, b_fail, b_miss, b_chk, b_ffi,
            b_fseen, b_allp, b_cyc, b_bh};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load(input int idx, input int inst, input int ans);
    load_en   = 1'b1;
    load_idx  = 6'(idx);
    load_inst = 16'(inst);
    load_ans  = 16'(ans);
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 64; i++) load(i, 16'hFFFF, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic cyc(input int n, input int op, input logic h);
    num_inst    = 16'(n);
    output_port = 16'(op);
    is_halted   = h;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    qa.push_back(mk(0,0,3,0,0,0,0,0,0,0,0,0));
    qb.push_back(mk(0,0,3,0,0,0,0,0,0,0,0,0));
    e = qa.pop_front(); o = obs_a(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_a got=%h exp=%h", o, e); end
    e = qb.pop_front(); o = obs_b(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_b got=%h exp=%h", o, e); end
  endtask

  // Three matching entries, halt on the last; loads during RUN/DONE must be ignored
  task automatic test_halt_pass();
    do_reset();
    clear_table();
    load(0, 3, 0); load(1, 5, 0); load(2, 7, 2);
    num_branch = 16'd10; num_branch_miss = 16'd13;
    pulse_start();
    load_en = 1'b1; load_idx = 6'd0; load_inst = 16'd100; load_ans = 16'd9;
    cyc(3, 0, 1'b0);
    load_en = 1'b0;
    cyc(5, 0, 1'b0);
    qa.push_back(mk(1,0,0,3,0,0,3,0,0,0,3,16'hFFFD));
    qb.push_back(mk(1,0,0,3,0,0,3,0,0,1,3,16'hFFFD));
    cyc(7, 2, 1'b1);
    is_halted = 1'b0;
    e = qa.pop_front(); o = obs_a(); total++;
    if (o !== e) begin bad++; $display("FAIL halt_pass_a got=%h exp=%h", o, e); end
    e = qb.pop_front(); o = obs_b(); total++;
    if (o !== e) begin bad++; $display("FAIL halt_pass_b got=%h exp=%h", o, e); end
    load(1, 100, 9);
    qa.push_back(mk(0,0,0,3,0,0,3,0,0,0,3,16'hFFFD));
    qb.push_back(mk(0,0,0,3,0,0,3,0,0,0,3,16'hFFFD));
    pulse_start();
    e = qa.pop_front(); o = obs_a(); total++;
    if (o !== e) begin bad++; $display("FAIL done_to_idle_a got=%h exp=%h", o, e); end
    e = qb.pop_front(); o = obs_b(); total++;
    if (o !== e) begin bad++; $display("FAIL done_to_idle_b got=%h exp=%h", o, e); end
  endtask

  // Reset mid-run, then rerun the previous table without reloading it
  task automatic test_reset_midrun();
    pulse_start();
    cyc(3, 0, 1'b0); cyc(5, 0, 1'b0); cyc(5, 0, 1'b0); cyc(5, 0, 1'b0);
    reset_n = 1'b0;
    #1;
    qa.push_back(mk(0,0,3,0,0,0,0,0,0,0,0,0));
    e = qa.pop_front(); o = obs_a(); total++;
    if (o !== e) begin bad++; $display("FAIL midrun_reset_a got=%h exp=%h", o, e); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_start();
    cyc(3, 0, 1'b0);
    cyc(5, 0, 1'b0);
    qa.push_back(mk(1,0,0,3,0,0,3,0,0,0,3,16'hFFFD));
    qb.push_back(mk(1,0,0,3,0,0,3,0,0,1,3,16'hFFFD));
    cyc(7, 2, 1'b1);
    is_halted = 1'b0;
    e = qa.pop_front(); o = obs_a(); total++;
    if (o !== e) begin bad++; $display("FAIL rerun_a got=%h exp=%h", o, e); end
    e = qb.pop_front(); o = obs_b(); total++;
    if (o !== e) begin bad++; $display("FAIL rerun_b got=%h exp=%h", o, e); end
  endtask

  // Mismatch on the second entry stops the run on that cycle
  task automatic test_fail();
    do_reset();
    clear_table();
    load(0, 4, 4); load(1, 11, 1);
    num_branch = 16'd0; num_branch_miss = 16'd0;
    pulse_start();
    cyc(4, 4, 1'b0);
    qa.push_back(mk(1,0,1,1,1,0,2,1,1,0,2,16'h0));
    qb.push_back(mk(1,0,1,1,1,0,2,1,1,0,2,16'h0));
    cyc(11, 2, 1'b0);
    e = qa.pop_front(); o = obs_a(); total++;
    if (o !== e) begin bad++; $display("FAIL stop_on_fail_a got=%h exp=%h", o, e); end
    e = qb.pop_front(); o = obs_b(); total++;
    if (o !== e) begin bad++; $display("FAIL stop_on_fail_b got=%h exp=%h", o, e); end
  endtask

  // num_inst jumps past two entries: one miss per cycle, then a hit
  task automatic test_skip();
    do_reset();
    clear_table();
    load(0, 3, 0); load(1, 5, 0); load(2, 7, 0); load(3, 9, 0);
    pulse_start();
    cyc(3, 0, 1'b0);
    cyc(9, 0, 1'b0);
    cyc(9, 0, 1'b0);
    total++;
    if ({a_busy, a_pass, a_miss, a_chk} !== {1'b1, 7'd1, 7'd2, 7'd3}) begin
      bad++;
      $display("FAIL skip_mid_a got busy=%0d pass=%0d miss=%0d chk=%0d exp 1/1/2/3",
               a_busy, a_pass, a_miss, a_chk);
    end
    qa.push_back(mk(1,0,0,2,0,2,4,0,0,0,4,16'h0));
    qb.push_back(mk(1,0,0,1,0,2,3,0,0,0,4,16'h0));
    cyc(9, 0, 1'b1);
    is_halted = 1'b0;
    e = qa.pop_front(); o = obs_a(); total++;
    if (o !== e) begin bad++; $display("FAIL skip_a got=%h exp=%h", o, e); end
    e = qb.pop_front(); o = obs_b(); total++;
    if (o !== e) begin bad++; $display("FAIL skip_b got=%h exp=%h", o, e); end
  endtask

  // Held num_inst with equal-valued entries; small instance times out meanwhile
  task automatic test_hold();
    do_reset();
    clear_table();
    load(0, 5, 1); load(1, 5, 1); load(2, 6, 0);
    pulse_start();
    qb.push_back(mk(1,0,2,2,0,0,2,0,0,0,10,16'h0));
    for (int i = 0; i < 20; i++) cyc(5, 1, 1'b0);
    total++;
    if ({a_busy, a_pass, a_chk, a_cyc} !== {1'b1, 7'd2, 7'd2, 16'd20}) begin
      bad++;
      $display("FAIL hold_mid_a got busy=%0d pass=%0d chk=%0d cyc=%0d exp 1/2/2/20",
               a_busy, a_pass, a_chk, a_cyc);
    end
    e = qb.pop_front(); o = obs_b(); total++;
    if (o !== e) begin bad++; $display("FAIL hold_timeout_b got=%h exp=%h", o, e); end
    qa.push_back(mk(1,0,0,3,0,0,3,0,0,0,21,16'h0));
    cyc(6, 0, 1'b1);
    is_halted = 1'b0;
    e = qa.pop_front(); o = obs_a(); total++;
    if (o !== e) begin bad++; $display("FAIL hold_a got=%h exp=%h", o, e); end
  endtask

  // No halt: small instance ends after exactly 10 RUN cycles
  task automatic test_timeout();
    do_reset();
    pulse_start();
    qb.push_back(mk(1,0,2,0,0,0,0,0,0,0,10,16'h0));
    for (int i = 0; i < 9; i++) cyc(0, 0, 1'b0);
    total++;
    if ({b_busy, b_cyc} !== {1'b1, 16'd9}) begin
      bad++;
      $display("FAIL timeout_early_b got busy=%0d cyc=%0d exp 1/9", b_busy, b_cyc);
    end
    for (int i = 0; i < 6; i++) cyc(0, 0, 1'b0);
    e = qb.pop_front(); o = obs_b(); total++;
    if (o !== e) begin bad++; $display("FAIL timeout_b got=%h exp=%h", o, e); end
    total++;
    if ({a_busy, a_cyc} !== {1'b1, 16'd15}) begin
      bad++;
      $display("FAIL timeout_run_a got busy=%0d cyc=%0d exp 1/15", a_busy, a_cyc);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_halt_pass();
    test_reset_midrun();
    test_fail();
    test_skip();
    test_hold();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 Parameter WORD_SIZE, default 16, width of instruction-count, answer and branch-count words.
REQ-002 Parameter NUM_TEST, default 56, number of expected-result entries.
REQ-003 Parameter IDX_W, default 6, entry index width; ceil(log2(NUM_TEST)) <= IDX_W.
REQ-004 Parameter MAX_CYCLES, default 10000, cycle budget before timeout.
REQ-005 Parameter CYC_W, default 16, cycle counter width.
REQ-006 Parameter STOP_ON_FAIL, default 1; 1 ends the run on the first mismatch, 0 continues.
REQ-007 clk  in  1  single clock; all state changes on posedge clk.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 load_en  in  1  write one table entry this cycle.
REQ-010 load_idx  in  IDX_W  entry index to write.
REQ-011 load_inst  in  WORD_SIZE  instruction count at which the entry is checked.
REQ-012 load_ans  in  WORD_SIZE  expected output_port value.
REQ-013 start  in  1  begin a checking run.
REQ-014 num_inst, output_port  in  WORD_SIZE each  DUT retired-instruction count and WWD port.
REQ-015 is_halted  in  1  DUT halt flag.
REQ-016 num_branch, num_branch_miss  in  WORD_SIZE each  DUT branch statistics.
REQ-017 busy, done  out  1 each  run in progress / run finished.
REQ-018 done_cause  out  2  0 halt, 1 fail, 2 timeout, 3 none.
REQ-019 pass_count, fail_count, miss_count, checked_count  out  IDX_W+1 each  entry tallies.
REQ-020 first_fail_idx  out  IDX_W  index of first mismatching entry; fail_seen  out  1.
REQ-021 all_pass  out  1  set in DONE iff pass_count == NUM_TEST.
REQ-022 cycle_count  out  CYC_W  cycles spent in RUN.
REQ-023 branch_hit  out  WORD_SIZE  num_branch - num_branch_miss, latched on entering DONE, modulo 2^WORD_SIZE.

Function
REQ-024 States IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on an end condition; DONE->IDLE on start (begins a new run next start).
REQ-025 Table writes accepted only in IDLE; load_en in RUN/DONE ignored; load_idx >= NUM_TEST ignored.
REQ-026 Table entries are sorted ascending by load_inst; equal values are legal and checked on consecutive cycles.
REQ-027 Entering RUN clears pointer, all counts, fail_seen, first_fail_idx, cycle_count, and sets done_cause = 3.
REQ-028 In RUN, one entry (pointer p) examined per cycle while p < NUM_TEST.
REQ-029 num_inst == inst[p]: output_port == ans[p] -> pass_count+1, else fail_count+1; p+1; checked_count+1.
REQ-030 num_inst > inst[p] (entry skipped): miss_count+1, p+1, checked_count+1.
REQ-031 num_inst < inst[p]: no action; a num_inst held constant over many cycles never rechecks an advanced entry.
REQ-032 First mismatch sets fail_seen and first_fail_idx = p; later mismatches leave both unchanged.
REQ-033 cycle_count increments every RUN cycle, saturating at 2^CYC_W-1.
REQ-034 End conditions evaluated after the same-cycle check: mismatch with STOP_ON_FAIL=1 -> cause 1; else is_halted -> cause 0; else cycle_count+1 == MAX_CYCLES -> cause 2.
REQ-035 Priority fail > halt > timeout when coincident; the check on the halting cycle counts.
REQ-036 p reaching NUM_TEST does not end the run; monitor waits for halt or timeout.
REQ-037 busy = (state == RUN); done = (state == DONE); all tallies hold in DONE until next start.
REQ-038 start in RUN ignored.

Reset
REQ-039 reset_n low forces IDLE asynchronously; busy, done, fail_seen, all_pass = 0; all counts, first_fail_idx, cycle_count, branch_hit = 0; done_cause = 3.
REQ-040 Table contents are not reset; reset mid-run abandons the run, table usable by the next start without reload.

Verification
REQ-041 Load 3 entries (3,0),(5,0),(7,2); start; drive num_inst 3,5,7 with matching output_port, halt at 7 -> done, cause 0, pass_count 3, all_pass only if NUM_TEST=3.
REQ-042 STOP_ON_FAIL=1, entry (11,1), output_port 2 at num_inst 11 -> done next cycle, cause 1, fail_count 1, first_fail_idx of that entry.
REQ-043 num_inst jumps 3->9 past entries 5,7 -> miss_count 2 over two cycles, then entry 9 checked.
REQ-044 num_inst held at 5 for 20 cycles -> entry 5 counted once, cycle_count 20 more.
REQ-045 MAX_CYCLES=10, no halt -> done after 10 RUN cycles, cause 2, cycle_count 10.
REQ-046 reset_n low mid-run at cycle 4 -> immediate IDLE, counts 0; restart reproduces REQ-041 result without reload.
